// File: rtl/rst_seq_ctrl.sv
// PLL/reset sequencer: pulses the PLL reset, qualifies lock over time, then releases
// NUM_RST active-low reset domains one at a time in index order.
module rst_seq_ctrl #(
  parameter int NUM_RST         = 4,
  parameter int PLL_RST_CYC     = 8,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int STAGE_GAP       = 16
) (
  input  logic               ext_clk,
  input  logic               ext_rst_n,
  input  logic               pll_locked,
  input  logic               soft_rst_req,
  output logic               pll_areset,
  output logic [NUM_RST-1:0] rst_n,
  output logic               seq_done,
  output logic [7:0]         retry_cnt,
  output logic [7:0]         lock_lost_cnt,
  output logic [2:0]         state_o
);

  localparam int REL_CYC = STAGE_GAP * NUM_RST;
  localparam int MAX_A   = (PLL_RST_CYC > LOCK_STABLE_CYC) ? PLL_RST_CYC : LOCK_STABLE_CYC;
  localparam int MAX_B   = (LOCK_TIMEOUT > REL_CYC) ? LOCK_TIMEOUT : REL_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] REL_LAST     = CNT_W'(REL_CYC - 1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    HOLD      = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         rst_sync_q, rst_sync_d;
  logic [1:0]         lock_sync_q, lock_sync_d;
  logic               pll_areset_q, pll_areset_d;
  logic [NUM_RST-1:0] rst_n_q, rst_n_d;
  logic               seq_done_q, seq_done_d;
  logic [7:0]         retry_q, retry_d;
  logic [7:0]         lost_q, lost_d;
  logic               rst_ok;
  logic               lock_s;

  // Assertion of ext_rst_n is immediate; release reaches the FSM two edges later.
  assign rst_sync_d  = {rst_sync_q[0], 1'b1};
  assign lock_sync_d = {lock_sync_q[0], pll_locked};
  assign rst_ok      = rst_sync_q[1];
  assign lock_s      = lock_sync_q[1];

  always_ff @(posedge ext_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      rst_sync_q   <= '0;
      lock_sync_q  <= '0;
      pll_areset_q <= 1'b1;
      rst_n_q      <= '0;
      seq_done_q   <= 1'b0;
      retry_q      <= '0;
      lost_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rst_sync_q   <= rst_sync_d;
      lock_sync_q  <= lock_sync_d;
      pll_areset_q <= pll_areset_d;
      rst_n_q      <= rst_n_d;
      seq_done_q   <= seq_done_d;
      retry_q      <= retry_d;
      lost_q       <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!rst_ok) begin
      state_d = PLL_RST;
    end else begin
      unique case (state_q)
        PLL_RST:   if (cnt_q == PLL_LAST) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s)                     state_d = STABLE;
          else if (cnt_q == TIMEOUT_LAST) state_d = PLL_RST;
        end
        STABLE: begin
          if (!lock_s)                    state_d = WAIT_LOCK;
          else if (cnt_q == STABLE_LAST)  state_d = RELEASE;
        end
        RELEASE: begin
          if (!lock_s)                    state_d = WAIT_LOCK;
          else if (cnt_q == REL_LAST)     state_d = RUN;
        end
        // Lock loss outranks a simultaneous soft request.
        RUN: begin
          if (!lock_s)                    state_d = WAIT_LOCK;
          else if (soft_rst_req)          state_d = HOLD;
        end
        HOLD:      if (cnt_q == GAP_LAST) state_d = RELEASE;
        default:   state_d = PLL_RST;
      endcase
    end

    cnt_d = cnt_q + 1'b1;
    if (!rst_ok || state_d != state_q || state_q == RUN) cnt_d = '0;
  end

  always_comb begin
    pll_areset_d = (state_d == PLL_RST);
    seq_done_d   = (state_d == RUN);

    rst_n_d = '0;
    if (state_d == RUN) begin
      rst_n_d = '1;
    end else if (state_d == RELEASE) begin
      rst_n_d = rst_n_q;
      if (state_q == RELEASE) begin
        for (int i = 0; i < NUM_RST; i++) begin
          if (cnt_q == CNT_W'(STAGE_GAP * (i + 1) - 1)) rst_n_d[i] = 1'b1;
        end
      end
    end

    retry_d = retry_q;
    if (state_q == WAIT_LOCK && state_d == PLL_RST && retry_q != 8'hFF)
      retry_d = retry_q + 8'd1;

    lost_d = lost_q;
    if ((state_q == RELEASE || state_q == RUN) && state_d == WAIT_LOCK && lost_q != 8'hFF)
      lost_d = lost_q + 8'd1;
  end

  assign pll_areset    = pll_areset_q;
  assign rst_n         = rst_n_q;
  assign seq_done      = seq_done_q;
  assign retry_cnt     = retry_q;
  assign lock_lost_cnt = lost_q;
  assign state_o       = state_q;

endmodule
